// File: rtl/decodificador_circuito_cinco.sv
// Receive side of the circuitocinco code: deserialises framed 4-bit words,
// decodes them to a canonical 3-bit value plus candidate mask, with status.
module decodificador_circuito_cinco #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_valid,
    input  logic             sin_sof,
    input  logic             sin_bit,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic             b2,
    output logic             b1,
    output logic             b0,
    output logic [7:0]       cand_mask,
    output logic             cod_err,
    output logic             ovf,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             clr_stat
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [3:0] sr;
    logic [2:0] b_q;

    logic       frame_err;
    logic       word_done;
    logic [3:0] word;
    logic [2:0] dec_b;
    logic [7:0] dec_mask;
    logic       dec_err;
    logic       pop;
    logic       load;
    logic       drop;
    logic       err_inc;

    assign frame_err = (state == SHIFT) && sin_valid && sin_sof;
    assign word_done = (state == SHIFT) && sin_valid && !sin_sof && (cnt == 3'd3);
    assign word      = {sr[2:0], sin_bit};
    assign pop       = dec_valid && dec_ready;
    assign load      = word_done && (!dec_valid || dec_ready);
    assign drop      = word_done && dec_valid && !dec_ready;
    assign err_inc   = frame_err || (word_done && dec_err);

    assign b2 = b_q[2];
    assign b1 = b_q[1];
    assign b0 = b_q[0];

    // Canonical value is the lowest b whose encoding matches the word.
    always_comb begin
        dec_b    = 3'd0;
        dec_mask = 8'h00;
        dec_err  = 1'b0;
        case (word)
            4'b0101: begin dec_b = 3'd0; dec_mask = 8'h21; end
            4'b0011: begin dec_b = 3'd1; dec_mask = 8'h12; end
            4'b0001: begin dec_b = 3'd2; dec_mask = 8'h0C; end
            4'b0111: begin dec_b = 3'd6; dec_mask = 8'h40; end
            4'b1001: begin dec_b = 3'd7; dec_mask = 8'h80; end
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            dec_valid <= 1'b0;
            b_q       <= '0;
            cand_mask <= '0;
            cod_err   <= 1'b0;
            ovf       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sin_valid && sin_sof) begin
                        state <= SHIFT;
                        sr    <= {3'b000, sin_bit};
                        cnt   <= 3'd1;
                    end
                end
                SHIFT: begin
                    if (sin_valid) begin
                        if (sin_sof) begin
                            // Framing error: drop partial word, this bit restarts as y3.
                            sr  <= {3'b000, sin_bit};
                            cnt <= 3'd1;
                        end else if (cnt == 3'd3) begin
                            state <= IDLE;
                            cnt   <= '0;
                            sr    <= '0;
                        end else begin
                            sr  <= {sr[2:0], sin_bit};
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                dec_valid <= 1'b1;
                b_q       <= dec_b;
                cand_mask <= dec_mask;
                cod_err   <= dec_err;
            end else if (pop) begin
                dec_valid <= 1'b0;
            end

            if (clr_stat) begin
                ovf     <= 1'b0;
                err_cnt <= '0;
            end else begin
                if (drop)
                    ovf <= 1'b1;
                if (err_inc && (err_cnt != '1))
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decodificador_circuito_cinco.sv
// Scoreboard bench for decodificador_circuito_cinco: randomized framed words
// checked against an encode-table reference model.
module tb_decodificador_circuito_cinco;

    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sin_valid, sin_sof, sin_bit;
    logic             dec_valid, dec_ready;
    logic             b2, b1, b0;
    logic [7:0]       cand_mask;
    logic             cod_err, ovf, clr_stat;
    logic [ERR_W-1:0] err_cnt;

    decodificador_circuito_cinco #(.ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .sin_valid(sin_valid), .sin_sof(sin_sof), .sin_bit(sin_bit),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .b2(b2), .b1(b1), .b0(b0),
        .cand_mask(cand_mask), .cod_err(cod_err),
        .ovf(ovf), .err_cnt(err_cnt), .clr_stat(clr_stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int b;
        int mask;
        int err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_busy, m_n, m_word, m_full, m_ovf, m_err;
    int last_b, last_mask, last_err;

    // Encoder of the forward code: b -> y3..y0
    function automatic int enc(input int b);
        case (b)
            0: return 5;  1: return 3;  2: return 1;  3: return 1;
            4: return 3;  5: return 5;  6: return 7;  default: return 9;
        endcase
    endfunction

    function automatic exp_t decode_ref(input int w);
        exp_t e;
        e.mask = 0;
        e.b    = -1;
        for (int i = 7; i >= 0; i--)
            if (enc(i) == w) begin
                e.mask |= (1 << i);
                e.b     = i;
            end
        e.err = (e.mask == 0) ? 1 : 0;
        if (e.b < 0) e.b = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_n = 0; m_word = 0; m_full = 0; m_ovf = 0; m_err = 0;
        last_b = 0; last_mask = 0; last_err = 0;
        q.delete();
    endtask

    // Applies one clock edge of the specified behaviour to the model.
    task automatic model_edge(input int v, input int s, input int bt, input int rdy, input int clr);
        int   pop, done, fr, ill, dropped;
        exp_t e;
        pop = m_full && rdy;
        done = 0; fr = 0; ill = 0; dropped = 0;
        if (v) begin
            if (s) begin
                if (m_busy) fr = 1;
                m_busy = 1; m_word = bt; m_n = 1;
            end else if (m_busy) begin
                m_word = m_word * 2 + bt;
                m_n++;
                if (m_n == 4) begin done = 1; m_busy = 0; end
            end
        end
        if (done) begin
            e   = decode_ref(m_word);
            ill = e.err;
            if (!m_full || pop) begin q.push_back(e); m_full = 1; end
            else dropped = 1;
        end else if (pop) m_full = 0;
        if (clr) begin
            m_ovf = 0; m_err = 0;
        end else begin
            if (dropped) m_ovf = 1;
            if ((fr || ill) && m_err < ERR_MAX) m_err++;
        end
    endtask

    task automatic step(input int v, input int s, input int bt, input int rdy, input int clr);
        sin_valid = v[0]; sin_sof = s[0]; sin_bit = bt[0];
        dec_ready = rdy[0]; clr_stat = clr[0];
        @(posedge clk);
        model_edge(v, s, bt, rdy, clr);
        #1;
    endtask

    function automatic int pick_rdy(input int mode);
        return (mode == 2) ? int'($urandom_range(0, 1)) : mode;
    endfunction

    // mode: 0 ready low, 1 ready high, 2 random; gaps inserts idle cycles.
    task automatic send_word(input int w, input int mode, input int gaps);
        for (int i = 3; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 0, pick_rdy(mode), 0);
            step(1, (i == 3) ? 1 : 0, (w >> i) & 1, pick_rdy(mode), 0);
        end
    endtask

    task automatic idle(input int n, input int rdy);
        repeat (n) step(0, 0, 0, rdy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_dec_valid", int'(dec_valid), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_b", int'({b2, b1, b0}), 0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("dec_valid", int'(dec_valid), m_full);
            chk("ovf", int'(ovf), m_ovf);
            chk("err_cnt", int'(err_cnt), m_err);
            if (dec_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("b", int'({b2, b1, b0}), q[0].b);
                    chk("cand_mask", int'(cand_mask), q[0].mask);
                    chk("cod_err", int'(cod_err), q[0].err);
                    if (dec_ready) begin
                        last_b = q[0].b; last_mask = q[0].mask; last_err = q[0].err;
                        void'(q.pop_front());
                    end
                end
            end else begin
                chk("hold_b", int'({b2, b1, b0}), last_b);
                chk("hold_mask", int'(cand_mask), last_mask);
                chk("hold_err", int'(cod_err), last_err);
            end
        end
    end

    initial begin
        int w, r;
        rst_n = 1'b0; sin_valid = 0; sin_sof = 0; sin_bit = 0;
        dec_ready = 0; clr_stat = 0;
        model_reset();
        #12 rst_n = 1'b1;

        // Legal words, one per canonical value
        send_word(4'b0101, 1, 0);
        send_word(4'b0011, 1, 0);
        send_word(4'b0001, 1, 0);
        send_word(4'b0111, 1, 0);
        send_word(4'b1001, 1, 0);
        idle(2, 1);
        send_word(4'b1111, 1, 0);
        idle(2, 1);

        // Framing error: two bits of 0101 then a fresh word
        step(1, 1, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        send_word(4'b0011, 1, 0);
        idle(2, 1);

        // Overflow with the consumer stalled
        send_word(4'b0111, 0, 0);
        send_word(4'b1001, 0, 0);
        idle(3, 0);
        idle(3, 1);

        // Pop coincides with the last bit of a new word
        send_word(4'b0011, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        idle(3, 1);

        // Reset mid-word; trailing bits without sof are ignored
        step(1, 1, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        do_reset();
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        idle(2, 1);

        // Saturation then clear
        repeat (5) send_word(4'b1110, 1, 0);
        idle(2, 1);
        step(0, 0, 0, 1, 1);
        idle(2, 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 8) begin
                step(0, 0, 0, pick_rdy(2), 1);
            end else if (r < 18) begin
                w = $urandom_range(1, 3);
                step(1, 1, $urandom_range(0, 1), pick_rdy(2), 0);
                for (int k = 1; k < w; k++) step(1, 0, $urandom_range(0, 1), pick_rdy(2), 0);
            end else if (r < 22) begin
                step(1, 0, $urandom_range(0, 1), pick_rdy(2), 0);
            end else begin
                w = (r < 60) ? enc($urandom_range(0, 7)) : int'($urandom_range(0, 15));
                send_word(w, 2, 1);
            end
        end

        idle(6, 1);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global timeout
    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
